// File: rtl/sv_cmd_rx.sv
// sv_cmd_rx - framed command receiver.
//
// Receives 4-byte frames {HDR, ADDR, DATA, CHK} on a valid/ready byte
// stream, checks CHK == HDR ^ ADDR ^ DATA and presents the decoded command
// on a valid/ready command port. Checksum failures and inter-byte timeouts
// are counted (saturating) and signalled with a one-cycle pulse.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | hunting for the header byte, other bytes silently dropped
// ADDR  | header seen, waiting for the address byte
// DATA  | waiting for the data byte
// CHK   | waiting for the checksum byte
// OUT   | command presented, waiting for the downstream handshake
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   byte available on in_data
//   in_data    incoming byte
//   in_ready   byte accepted this cycle when high (low only in OUT)
//   cmd_valid  command held on cmd_addr/cmd_data
//   cmd_ready  downstream consumes the command
//   cmd_addr   command address
//   cmd_data   command payload
//   err_cnt    saturating checksum/timeout error count
//   err_pulse  one-cycle pulse per error event
//   busy       high whenever not in IDLE
module sv_cmd_rx #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_addr,
  output logic [7:0] cmd_data,
  output logic [7:0] err_cnt,
  output logic       err_pulse,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_CHK,
    S_OUT
  } state_t;

  // Abort happens on the idle cycle that would bring the count to TIMEOUT.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] tmo_cnt;
  logic        accept;

  assign accept = in_valid && in_ready;

  // in_ready, cmd_valid and busy are registered alongside every state
  // change so no input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      in_ready  <= 1'b1;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
      cmd_addr  <= '0;
      cmd_data  <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && (in_data == HDR)) begin
            state   <= S_ADDR;
            busy    <= 1'b1;
            tmo_cnt <= '0;
          end
        end

        S_ADDR, S_DATA, S_CHK: begin
          if (accept) begin
            // an accepted byte always wins over a coincident timeout
            tmo_cnt <= '0;
            case (state)
              S_ADDR: begin
                cmd_addr <= in_data;
                state    <= S_DATA;
              end
              S_DATA: begin
                cmd_data <= in_data;
                state    <= S_CHK;
              end
              default: begin
                if (in_data == (HDR ^ cmd_addr ^ cmd_data)) begin
                  state     <= S_OUT;
                  in_ready  <= 1'b0;
                  cmd_valid <= 1'b1;
                end else begin
                  state     <= S_IDLE;
                  busy      <= 1'b0;
                  err_pulse <= 1'b1;
                  if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
              end
            endcase
          end else if (tmo_cnt == TMO_LAST) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            tmo_cnt   <= '0;
            err_pulse <= 1'b1;
            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        S_OUT: begin
          if (cmd_ready) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          tmo_cnt   <= '0;
          in_ready  <= 1'b1;
          cmd_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sv_cmd_rx.sv
// tb_sv_cmd_rx - self-checking bench for sv_cmd_rx.
// A frame-level reference model (queue of collected bytes, idle counter,
// pending-command flag) predicts every output after each clock edge.
module tb_sv_cmd_rx;

  localparam int unsigned TO  = 4;
  localparam logic [7:0]  HDR = 8'hA5;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [7:0] err_cnt;
  logic       err_pulse;
  logic       busy;

  sv_cmd_rx #(.TIMEOUT(TO), .HDR(HDR)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .err_cnt   (err_cnt),
    .err_pulse (err_pulse),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  logic [7:0] m_frame[$];
  int         m_idle;
  bit         m_pending;
  logic [7:0] m_addr;
  logic [7:0] m_data;
  int         m_err_cnt;
  bit         m_err_pulse;

  task automatic m_error();
    m_err_pulse = 1'b1;
    if (m_err_cnt < 255) m_err_cnt++;
    m_frame.delete();
    m_idle = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic cr, input logic r);
    if (r) begin
      m_frame.delete();
      m_idle      = 0;
      m_pending   = 1'b0;
      m_err_cnt   = 0;
      m_err_pulse = 1'b0;
    end else begin
      m_err_pulse = 1'b0;
      if (m_pending) begin
        if (cr) m_pending = 1'b0;
      end else if (m_frame.size() == 0) begin
        if (v && d == HDR) begin
          m_frame.push_back(d);
          m_idle = 0;
        end
      end else if (v) begin
        m_frame.push_back(d);
        m_idle = 0;
        if (m_frame.size() == 4) begin
          if ((m_frame[0] ^ m_frame[1] ^ m_frame[2]) == m_frame[3]) begin
            m_pending = 1'b1;
            m_addr    = m_frame[1];
            m_data    = m_frame[2];
            m_frame.delete();
          end else begin
            m_error();
          end
        end
      end else begin
        m_idle++;
        if (m_idle == int'(TO)) m_error();
      end
    end
  endtask

  task automatic compare_all();
    check("in_ready",  in_ready,  !m_pending);
    check("cmd_valid", cmd_valid, m_pending);
    check("busy",      busy,      m_pending || (m_frame.size() != 0));
    check("err_pulse", err_pulse, m_err_pulse);
    check("err_cnt",   err_cnt,   m_err_cnt);
    if (m_pending) begin
      check("cmd_addr", cmd_addr, m_addr);
      check("cmd_data", cmd_data, m_data);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] d, input logic cr, input logic r);
    in_valid  = v;
    in_data   = d;
    cmd_ready = cr;
    rst       = r;
    @(posedge clk);
    model_step(v, d, cr, r);
    #1;
    compare_all();
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'($urandom), 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("rst_addr", cmd_addr, 8'h00);
    check("rst_data", cmd_data, 8'h00);
    check("rst_err",  err_cnt,  8'h00);
    check("rst_busy", busy,     1'b0);
    check("rst_cv",   cmd_valid, 1'b0);
    check("rst_rdy",  in_ready, 1'b1);
    check("rst_pls",  err_pulse, 1'b0);
  endtask

  task automatic rand_frame(input bit good);
    logic [7:0] a;
    logic [7:0] dd;
    logic [7:0] c;
    logic [7:0] fb[4];
    a  = 8'($urandom);
    dd = 8'($urandom);
    c  = HDR ^ a ^ dd;
    if (!good) c = c ^ 8'($urandom_range(1, 255));
    fb[0] = HDR; fb[1] = a; fb[2] = dd; fb[3] = c;
    for (int i = 0; i < 4; i++) begin
      // gaps occasionally reach the timeout
      int gap;
      gap = ($urandom_range(0, 5) == 0) ? $urandom_range(0, TO) : 0;
      for (int g = 0; g < gap; g++)
        cyc(1'b0, 8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
      cyc(1'b1, fb[i], ($urandom_range(0, 3) != 0), 1'b0);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = 8'h00;
    cmd_ready = 1'b0;
    rst       = 1'b1;
    m_idle = 0; m_pending = 1'b0; m_addr = '0; m_data = '0;
    m_err_cnt = 0; m_err_pulse = 1'b0;
    do_reset();
    do_reset();

    // good frame back-to-back
    send(8'hA5); send(8'h12); send(8'h34); send(8'h83);
    check("g_cv",   cmd_valid, 1'b1);
    check("g_addr", cmd_addr,  8'h12);
    check("g_data", cmd_data,  8'h34);
    check("g_err",  err_cnt,   8'h00);
    send(8'h00);
    check("g_done", cmd_valid, 1'b0);

    // bad checksum then a good frame
    send(8'hA5); send(8'h12); send(8'h34); send(8'h00);
    check("b_cv",  cmd_valid, 1'b0);
    check("b_pls", err_pulse, 1'b1);
    check("b_err", err_cnt,   8'h01);
    check("b_bsy", busy,      1'b0);
    idle(1);
    check("b_pls2", err_pulse, 1'b0);
    send(8'hA5); send(8'h56); send(8'h78); send(HDR ^ 8'h56 ^ 8'h78);
    check("b2_addr", cmd_addr, 8'h56);
    check("b2_data", cmd_data, 8'h78);
    send(8'h00);

    // leading junk dropped
    do_reset();
    send(8'h00); send(8'hFF); send(8'hA5); send(8'h01); send(8'h02); send(8'hA6);
    check("j_cv",   cmd_valid, 1'b1);
    check("j_addr", cmd_addr,  8'h01);
    check("j_data", cmd_data,  8'h02);
    check("j_err",  err_cnt,   8'h00);
    send(8'h00);

    // timeout, then a byte on the last permitted idle cycle
    do_reset();
    send(8'hA5); idle(TO);
    check("t_bsy", busy,      1'b0);
    check("t_err", err_cnt,   8'h01);
    check("t_pls", err_pulse, 1'b1);
    send(8'hA5); idle(TO - 1); send(8'h21);
    check("t2_bsy", busy,    1'b1);
    check("t2_err", err_cnt, 8'h01);
    idle(TO - 1); send(8'h43); send(HDR ^ 8'h21 ^ 8'h43);
    check("t2_cv",  cmd_valid, 1'b1);
    check("t2_adr", cmd_addr,  8'h21);
    send(8'h00);

    // backpressure: command held while cmd_ready low, offered bytes ignored
    send(8'hA5); send(8'h9C); send(8'hA5); send(HDR ^ 8'h9C ^ HDR);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, HDR, 1'b0, 1'b0);
      check("bp_rdy",  in_ready, 1'b0);
      check("bp_addr", cmd_addr, 8'h9C);
      check("bp_data", cmd_data, 8'hA5);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("bp_cv", cmd_valid, 1'b0);
    check("bp_bsy", busy,     1'b0);
    // next header accepted straight after the handshake
    send(8'hA5);
    check("bp_hdr", busy, 1'b1);
    idle(TO);

    // error counter saturation
    do_reset();
    for (int k = 0; k < 260; k++) begin
      send(HDR); send(8'($urandom)); send(8'($urandom));
      send(8'(m_frame[0] ^ m_frame[1] ^ m_frame[2] ^ 8'h01));
      check("s_pls", err_pulse, 1'b1);
    end
    check("s_err", err_cnt, 8'hFF);
    send(8'hA5); send(8'h01);
    check("s_bsy", busy, 1'b1);
    cyc(1'b1, 8'h02, 1'b1, 1'b1);
    check("s_rst_err", err_cnt, 8'h00);
    check("s_rst_bsy", busy,    1'b0);
    check("s_rst_adr", cmd_addr, 8'h00);
    check("s_rst_dat", cmd_data, 8'h00);
    idle(2);

    // randomized traffic against the model
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 5))
        0, 1:    rand_frame(1'b1);
        2:       rand_frame(1'b0);
        3:       cyc(1'b1, 8'($urandom), ($urandom_range(0, 1) != 0), 1'b0);
        4:       cyc(1'b0, 8'($urandom), ($urandom_range(0, 1) != 0), 1'b0);
        default: cyc($urandom_range(0, 1) != 0, 8'($urandom),
                     $urandom_range(0, 1) != 0, ($urandom_range(0, 30) == 0));
      endcase
    end
    idle(TO + 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sv_cmd_rx.md
SV_CMD_RX -- requirements
Module: sv_cmd_rx

Interface
REQ-001 Parameter TIMEOUT, default 255: idle cycles allowed between bytes inside a frame before abort (range 1..65535).
REQ-002 Parameter HDR, default 8'hA5: frame header byte.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  byte available on in_data.
REQ-006 in_data  input  8  incoming byte, from the pin-level wrapper (ui_in path).
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 cmd_valid  output  1  decoded command held on cmd_addr/cmd_data.
REQ-009 cmd_ready  input  1  downstream consumes command.
REQ-010 cmd_addr  output  8  command address.
REQ-011 cmd_data  output  8  command payload.
REQ-012 err_cnt  output  8  saturating count of checksum and timeout errors.
REQ-013 err_pulse  output  1  one-cycle pulse on each error event.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Frame = 4 bytes in order: HDR, ADDR, DATA, CHK; CHK must equal HDR ^ ADDR ^ DATA.
REQ-016 Byte accepted only on cycle with in_valid && in_ready.
REQ-017 FSM states: IDLE, ADDR, DATA, CHK, OUT.
REQ-018 IDLE: in_ready=1; accepted byte == HDR -> ADDR; any other byte dropped, no error, stay IDLE.
REQ-019 ADDR: in_ready=1; accepted byte latched as address -> DATA.
REQ-020 DATA: in_ready=1; accepted byte latched as data -> CHK.
REQ-021 CHK: in_ready=1; accepted byte matching checksum -> OUT; mismatch -> IDLE, err_pulse next cycle, err_cnt+1.
REQ-022 OUT: in_ready=0, cmd_valid=1, cmd_addr/cmd_data stable until cmd_valid && cmd_ready; handshake cycle -> IDLE, cmd_valid=0 on next cycle.
REQ-023 No timeout in OUT; cmd_valid held indefinitely while cmd_ready=0.
REQ-024 Timeout counter: cleared on every accepted byte and on entry to ADDR; increments each cycle in ADDR/DATA/CHK without accepted byte; reaching TIMEOUT -> IDLE, err_pulse, err_cnt+1, partial frame discarded.
REQ-025 Byte accepted on the same cycle the counter would reach TIMEOUT takes priority; no timeout.
REQ-026 err_cnt saturates at 255; further errors still pulse err_pulse.
REQ-027 HDR value received as ADDR, DATA or CHK byte is treated as ordinary data, no resync.
REQ-028 Command latency: cmd_valid rises the cycle after CHK byte accepted.
REQ-029 Minimum frame-to-frame spacing: next HDR accepted the cycle after the cmd handshake.
REQ-030 err_pulse is registered; never high two consecutive cycles for one event.
REQ-031 Outputs are registered or decoded from FSM state only; no combinational path in_valid->in_ready or cmd_ready->cmd_valid.

Reset
REQ-032 rst=1 on a rising edge forces: state IDLE, in_ready=1 (after release), cmd_valid=0, cmd_addr=0, cmd_data=0, err_cnt=0, err_pulse=0, busy=0, timeout counter=0.
REQ-033 rst mid-frame or in OUT discards pending data; no cmd_valid, no error counted.
REQ-034 rst overrides all simultaneous handshakes in that cycle.

Verification
REQ-035 Bytes A5,12,34,83 back-to-back, cmd_ready=1 -> cmd_valid one cycle after CHK, cmd_addr=12, cmd_data=34, err_cnt=0.
REQ-036 Bytes A5,12,34,00 -> no cmd_valid, err_pulse one cycle, err_cnt=1, busy=0; following valid frame decoded correctly.
REQ-037 Bytes 00,FF,A5,01,02,A6 -> leading bytes dropped, command addr=01 data=02, err_cnt=0.
REQ-038 TIMEOUT=4: A5 then in_valid=0 for 4 cycles -> return IDLE, err_cnt=1; byte on 4th idle cycle instead -> no error.
REQ-039 Valid frame with cmd_ready=0 for 10 cycles -> cmd_valid/addr/data stable, in_ready=0, bytes offered ignored; cmd_ready=1 -> single handshake, IDLE.
REQ-040 Force 260 bad-checksum frames -> err_cnt=255, err_pulse each frame; rst asserted in DATA -> all outputs at reset values, err_cnt=0.
